// File: rtl/snake_game_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// snake_game_ctrl_pkg
// Shared definitions for the snake game sequencer and its turn queue:
// internal FSM state type, direction codes, externally visible state codes,
// the engine's post-reset length, and small helper functions.
// -----------------------------------------------------------------------------
package snake_game_ctrl_pkg;

  // Internal controller states; CLEAR is a one-cycle restart state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } ctrl_state_t;

  // Direction codes shared with the snake engine.
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  // Externally reported state codes.
  localparam logic [1:0] STATE_IDLE  = 2'b00;
  localparam logic [1:0] STATE_PLAY  = 2'b01;
  localparam logic [1:0] STATE_PAUSE = 2'b10;
  localparam logic [1:0] STATE_OVER  = 2'b11;

  // Engine snake length right after its reset.
  localparam int unsigned DEF_INIT_LEN = 32'd5;

  // Map an internal state onto its reported code (CLEAR reports as IDLE).
  function automatic logic [1:0] state_code(input ctrl_state_t s);
    logic [1:0] code;
    case (s)
      ST_IDLE:  code = STATE_IDLE;
      ST_CLEAR: code = STATE_IDLE;
      ST_PLAY:  code = STATE_PLAY;
      ST_PAUSE: code = STATE_PAUSE;
      ST_OVER:  code = STATE_OVER;
      default:  code = STATE_IDLE;
    endcase
    return code;
  endfunction

  // A turn is useless when it repeats the reference heading, and fatal when
  // it reverses it; opposite directions differ only in bit 1.
  function automatic logic turn_blocked(input logic [1:0] req, input logic [1:0] ref_dir);
    return (req == ref_dir) || (req == (ref_dir ^ 2'b10));
  endfunction

endpackage

// File: rtl/snake_dir_queue.sv
// -----------------------------------------------------------------------------
// snake_dir_queue
// Two-entry turn FIFO with duplicate/reversal filter. A request is compared
// against the newest queued turn, or against the live direction when empty.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   flush        - synchronous clear of all entries
//   push_valid   - a turn request is offered this cycle
//   push_dir     - requested direction
//   pop          - consume the head entry (ignored when empty)
//   cur_dir      - direction currently applied by the engine
//   head         - oldest queued turn
//   empty, full  - registered occupancy flags
// -----------------------------------------------------------------------------
module snake_dir_queue
  import snake_game_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push_valid,
  input  logic [1:0] push_dir,
  input  logic       pop,
  input  logic [1:0] cur_dir,
  output logic [1:0] head,
  output logic       empty,
  output logic       full
);

  logic [1:0] entry0_r;
  logic [1:0] entry1_r;
  logic [1:0] count_r;
  logic       empty_r;
  logic       full_r;

  logic [1:0] ref_dir_s;
  logic       pop_s;
  logic       push_s;
  logic [1:0] entry0_nx_s;
  logic [1:0] entry1_nx_s;
  logic [1:0] count_nx_s;

  // Reference heading for the filter: newest queued turn, else live direction.
  always_comb begin
    case (count_r)
      2'd0:    ref_dir_s = cur_dir;
      2'd1:    ref_dir_s = entry0_r;
      2'd2:    ref_dir_s = entry1_r;
      default: ref_dir_s = cur_dir;
    endcase
  end

  // Accept/pop decisions and next-state of the FIFO; a pop frees a slot in
  // the same cycle, so a full queue still accepts while it is being popped.
  always_comb begin
    pop_s       = pop && (count_r != 2'd0);
    push_s      = push_valid && !turn_blocked(push_dir, ref_dir_s) &&
                  ((count_r != 2'd2) || pop_s);
    entry0_nx_s = entry0_r;
    entry1_nx_s = entry1_r;
    count_nx_s  = count_r;
    case ({pop_s, push_s})
      2'b01: begin
        if (count_r == 2'd0) begin
          entry0_nx_s = push_dir;
        end else begin
          entry1_nx_s = push_dir;
        end
        count_nx_s = count_r + 2'd1;
      end
      2'b10: begin
        entry0_nx_s = entry1_r;
        count_nx_s  = count_r - 2'd1;
      end
      2'b11: begin
        if (count_r == 2'd1) begin
          entry0_nx_s = push_dir;
        end else begin
          entry0_nx_s = entry1_r;
          entry1_nx_s = push_dir;
        end
      end
      default: begin
        count_nx_s = count_r;
      end
    endcase
  end

  // FIFO storage and registered occupancy flags.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      entry0_r <= DIR_UP;
      entry1_r <= DIR_UP;
      count_r  <= 2'd0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      entry0_r <= entry0_nx_s;
      entry1_r <= entry1_nx_s;
      count_r  <= count_nx_s;
      empty_r  <= (count_nx_s == 2'd0);
      full_r   <= (count_nx_s == 2'd2);
    end
  end

  assign head  = entry0_r;
  assign empty = empty_r;
  assign full  = full_r;

endmodule

// File: rtl/snake_game_ctrl.sv
// -----------------------------------------------------------------------------
// snake_game_ctrl
// Game sequencer for the snake engine: idle/play/pause/over FSM, move tick
// generation with a level-dependent period, engine reset, and a buffered
// player turn queue.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   btn_up/right/down/left - one-cycle turn pulses
//   btn_start, btn_pause   - one-cycle control pulses
//   game_over         - level from the engine
//   snake_length      - engine snake length
//   move_tick         - one-cycle registered move strobe to the engine
//   direction         - applied heading (00 up, 01 right, 10 down, 11 left)
//   engine_reset      - registered engine reset
//   state             - 00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
//   level, score      - registered speed level and length above initial
// -----------------------------------------------------------------------------
module snake_game_ctrl
  import snake_game_ctrl_pkg::*;
#(
  parameter int unsigned BASE_PERIOD   = 32'd12500000,
  parameter int unsigned STEP_PERIOD   = 32'd1250000,
  parameter int unsigned MIN_PERIOD    = 32'd2500000,
  parameter int unsigned LEN_PER_LEVEL = 32'd4,
  parameter int unsigned INIT_LEN      = DEF_INIT_LEN,
  parameter int unsigned MAX_LEVEL     = 32'd15,
  parameter int unsigned CNT_W         = 32'd24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       game_over,
  input  logic [6:0] snake_length,
  output logic       move_tick,
  output logic [1:0] direction,
  output logic       engine_reset,
  output logic [1:0] state,
  output logic [3:0] level,
  output logic [6:0] score
);

  localparam logic [CNT_W-1:0] BASE_C = BASE_PERIOD[CNT_W-1:0];
  localparam logic [CNT_W-1:0] STEP_C = STEP_PERIOD[CNT_W-1:0];
  localparam logic [CNT_W-1:0] MIN_C  = MIN_PERIOD[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [6:0]       INIT_C = INIT_LEN[6:0];
  localparam logic [6:0]       LPL_C  = LEN_PER_LEVEL[6:0];
  localparam logic [6:0]       MAXL_C = MAX_LEVEL[6:0];

  ctrl_state_t      state_r;
  logic [1:0]       state_code_r;
  logic [CNT_W-1:0] counter_r;
  logic [CNT_W-1:0] period_r;
  logic             move_tick_r;
  logic             engine_reset_r;
  logic [1:0]       direction_r;
  logic [3:0]       level_r;
  logic [6:0]       score_r;

  logic             req_valid_s;
  logic [1:0]       req_dir_s;
  logic             tick_fire_s;
  logic             flush_s;
  logic [1:0]       q_head_s;
  logic             q_empty_s;
  logic             q_full_s;

  logic [6:0]       len_ex_s;
  logic [6:0]       lvl_raw_s;
  logic [3:0]       level_s;
  logic [CNT_W+3:0] dec_s;
  logic [CNT_W-1:0] period_s;

  // Turn request select: one per cycle, up > right > down > left, PLAY only.
  always_comb begin
    req_valid_s = 1'b0;
    req_dir_s   = DIR_UP;
    if (state_r == ST_PLAY) begin
      if (btn_up) begin
        req_valid_s = 1'b1;
        req_dir_s   = DIR_UP;
      end else if (btn_right) begin
        req_valid_s = 1'b1;
        req_dir_s   = DIR_RIGHT;
      end else if (btn_down) begin
        req_valid_s = 1'b1;
        req_dir_s   = DIR_DOWN;
      end else if (btn_left) begin
        req_valid_s = 1'b1;
        req_dir_s   = DIR_LEFT;
      end else begin
        req_valid_s = 1'b0;
      end
    end else begin
      req_valid_s = 1'b0;
    end
  end

  // Terminal count fires a move only when neither game_over nor pause wins.
  always_comb begin
    tick_fire_s = (state_r == ST_PLAY) && !game_over && !btn_pause &&
                  (counter_r == (period_r - ONE_C));
    flush_s     = (state_r == ST_CLEAR);
  end

  // Speed derivation; the period is clamped before subtracting so it can
  // never wrap below zero.
  always_comb begin
    if (snake_length >= INIT_C) begin
      len_ex_s = snake_length - INIT_C;
    end else begin
      len_ex_s = 7'd0;
    end
    lvl_raw_s = len_ex_s / LPL_C;
    if (lvl_raw_s > MAXL_C) begin
      level_s = MAXL_C[3:0];
    end else begin
      level_s = lvl_raw_s[3:0];
    end
    dec_s = {{CNT_W{1'b0}}, level_r} * {4'b0000, STEP_C};
    if ((dec_s + {4'b0000, MIN_C}) >= {4'b0000, BASE_C}) begin
      period_s = MIN_C;
    end else begin
      period_s = BASE_C - dec_s[CNT_W-1:0];
    end
  end

  snake_dir_queue u_dir_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush_s),
    .push_valid (req_valid_s),
    .push_dir   (req_dir_s),
    .pop        (tick_fire_s),
    .cur_dir    (direction_r),
    .head       (q_head_s),
    .empty      (q_empty_s),
    .full       (q_full_s)
  );

  // Game FSM with tick counter, direction, speed and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      state_code_r   <= STATE_IDLE;
      counter_r      <= '0;
      period_r       <= BASE_C;
      move_tick_r    <= 1'b0;
      engine_reset_r <= 1'b1;
      direction_r    <= DIR_UP;
      level_r        <= 4'd0;
      score_r        <= 7'd0;
    end else begin
      move_tick_r    <= 1'b0;
      // Engine reset follows the state one cycle late.
      engine_reset_r <= (state_r == ST_IDLE) || (state_r == ST_CLEAR);
      case (state_r)
        ST_IDLE: begin
          if (btn_start) begin
            state_r      <= ST_CLEAR;
            state_code_r <= state_code(ST_CLEAR);
          end
        end
        ST_CLEAR: begin
          counter_r    <= '0;
          period_r     <= BASE_C;
          direction_r  <= DIR_UP;
          level_r      <= 4'd0;
          score_r      <= 7'd0;
          state_r      <= ST_PLAY;
          state_code_r <= state_code(ST_PLAY);
        end
        ST_PLAY: begin
          level_r <= level_s;
          score_r <= len_ex_s;
          if (game_over) begin
            state_r      <= ST_OVER;
            state_code_r <= state_code(ST_OVER);
          end else if (btn_pause) begin
            // Counter stays frozen at its current value while paused.
            state_r      <= ST_PAUSE;
            state_code_r <= state_code(ST_PAUSE);
          end else if (tick_fire_s) begin
            counter_r   <= '0;
            move_tick_r <= 1'b1;
            period_r    <= period_s;
            if (!q_empty_s) begin
              direction_r <= q_head_s;
            end
          end else begin
            counter_r <= counter_r + ONE_C;
          end
        end
        ST_PAUSE: begin
          if (btn_pause || btn_start) begin
            state_r      <= ST_PLAY;
            state_code_r <= state_code(ST_PLAY);
          end
        end
        ST_OVER: begin
          if (btn_start) begin
            state_r      <= ST_CLEAR;
            state_code_r <= state_code(ST_CLEAR);
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          state_code_r <= STATE_IDLE;
        end
      endcase
    end
  end

  assign move_tick    = move_tick_r;
  assign direction    = direction_r;
  assign engine_reset = engine_reset_r;
  assign state        = state_code_r;
  assign level        = level_r;
  assign score        = score_r;

  // Occupancy flag is informational only; the filter handles fullness.
  logic unused_full_s;
  assign unused_full_s = q_full_s;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_game_ctrl
// Directed bench for snake_game_ctrl with BASE=10, STEP=2, MIN=4,
// LEN_PER_LEVEL=4, INIT_LEN=5. Expected values are queued when the stimulus
// is applied and compared in order when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_right, btn_down, btn_left, btn_start, btn_pause;
  logic       game_over;
  logic [6:0] snake_length;
  logic       move_tick;
  logic [1:0] direction;
  logic       engine_reset;
  logic [1:0] state;
  logic [3:0] level;
  logic [6:0] score;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  snake_game_ctrl #(
    .BASE_PERIOD   (32'd10),
    .STEP_PERIOD   (32'd2),
    .MIN_PERIOD    (32'd4),
    .LEN_PER_LEVEL (32'd4),
    .INIT_LEN      (32'd5),
    .MAX_LEVEL     (32'd15),
    .CNT_W         (32'd24)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_up       (btn_up),
    .btn_right    (btn_right),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_start    (btn_start),
    .btn_pause    (btn_pause),
    .game_over    (game_over),
    .snake_length (snake_length),
    .move_tick    (move_tick),
    .direction    (direction),
    .engine_reset (engine_reset),
    .state        (state),
    .level        (level),
    .score        (score)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
      end
    end
  endtask

  // Cycles until the next move_tick, bounded; a timeout reports 40.
  task automatic wait_tick(input string tag, input int exp_n);
    int n;
    n = 0;
    expect_v(tag, 32'(exp_n));
    while (n < 40) begin
      cyc();
      n++;
      if (move_tick === 1'b1) break;
    end
    check(32'(n));
  endtask

  task automatic count_ticks(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      cyc();
      if (move_tick === 1'b1) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1; btn_up = 1'b0; btn_right = 1'b0; btn_down = 1'b0; btn_left = 1'b0;
    btn_start = 1'b0; btn_pause = 1'b0; game_over = 1'b0; snake_length = 7'd5;

    // 1. reset values, start sequence and base tick period
    expect_v("rst_state", 32'd0);
    expect_v("rst_engine_reset", 32'd1);
    expect_v("rst_move_tick", 32'd0);
    expect_v("rst_direction", 32'd0);
    expect_v("rst_level", 32'd0);
    expect_v("rst_score", 32'd0);
    cyc(); cyc();
    check(32'(state)); check(32'(engine_reset)); check(32'(move_tick));
    check(32'(direction)); check(32'(level)); check(32'(score));
    reset = 1'b0;
    btn_start = 1'b1;
    expect_v("clear_state", 32'd0);
    expect_v("clear_engine_reset", 32'd1);
    cyc();
    btn_start = 1'b0;
    check(32'(state)); check(32'(engine_reset));
    expect_v("play_state", 32'd1);
    expect_v("play_p0_engine_reset", 32'd1);
    cyc();
    check(32'(state)); check(32'(engine_reset));
    expect_v("play_p1_engine_reset", 32'd0);
    cyc();
    check(32'(engine_reset));
    wait_tick("first_tick", 9);  // 10 cycles after PLAY entry (now at P1)
    wait_tick("second_tick", 10);
    expect_v("dir_initial", 32'd0);
    check(32'(direction));

    // 2. reversal rejected, queue fills to two, third press dropped
    btn_down = 1'b1; cyc(); btn_down = 1'b0;
    btn_right = 1'b1; cyc(); btn_right = 1'b0;
    btn_down = 1'b1; cyc(); btn_down = 1'b0;
    btn_left = 1'b1; cyc(); btn_left = 1'b0;
    expect_v("dir_before_pop", 32'd0);
    check(32'(direction));
    wait_tick("queue_tick1", 6);
    expect_v("dir_pop1", 32'd1);
    check(32'(direction));
    wait_tick("queue_tick2", 10);
    expect_v("dir_pop2", 32'd2);
    check(32'(direction));
    wait_tick("queue_tick3", 10);
    expect_v("dir_after_drop", 32'd2);
    check(32'(direction));

    // 3. speed levels
    snake_length = 7'd9;
    expect_v("lvl1_level", 32'd1);
    expect_v("lvl1_score", 32'd4);
    cyc();
    check(32'(level)); check(32'(score));
    wait_tick("lvl1_old_period", 9);
    wait_tick("lvl1_period8", 8);
    snake_length = 7'd25;
    expect_v("lvl5_level", 32'd5);
    expect_v("lvl5_score", 32'd20);
    cyc();
    check(32'(level)); check(32'(score));
    wait_tick("lvl5_old_period", 7);
    wait_tick("lvl5_period_floor", 4);
    snake_length = 7'd3;
    expect_v("short_level", 32'd0);
    expect_v("short_score", 32'd0);
    cyc();
    check(32'(level)); check(32'(score));
    wait_tick("short_old_period", 3);
    wait_tick("short_period10", 10);

    // 4. pause at counter 6, turn ignored, resume 4 counts before the tick
    repeat (6) cyc();
    btn_pause = 1'b1;
    expect_v("pause_state", 32'd2);
    cyc();
    btn_pause = 1'b0;
    check(32'(state));
    btn_right = 1'b1; cyc(); btn_right = 1'b0;
    expect_v("pause_no_ticks", 32'd0);
    count_ticks(50, n);
    check(32'(n));
    btn_pause = 1'b1;
    expect_v("resume_state", 32'd1);
    cyc();
    btn_pause = 1'b0;
    check(32'(state));
    wait_tick("resume_tick", 4);
    expect_v("pause_turn_ignored", 32'd2);
    check(32'(direction));

    // 5. game_over on terminal count, restart flushes queue and level
    snake_length = 7'd13;
    btn_left = 1'b1;
    expect_v("pre_over_score", 32'd8);
    expect_v("pre_over_level", 32'd2);
    cyc();
    btn_left = 1'b0;
    check(32'(score)); check(32'(level));
    repeat (8) cyc();
    game_over = 1'b1;
    expect_v("over_no_tick", 32'd0);
    expect_v("over_state", 32'd3);
    expect_v("over_dir_held", 32'd2);
    cyc();
    check(32'(move_tick)); check(32'(state)); check(32'(direction));
    snake_length = 7'd20;
    expect_v("over_score_held", 32'd8);
    expect_v("over_level_held", 32'd2);
    expect_v("over_ticks", 32'd0);
    count_ticks(12, n);
    check(32'(score)); check(32'(level)); check(32'(n));
    game_over = 1'b0;
    snake_length = 7'd5;
    btn_start = 1'b1;
    expect_v("restart_clear_state", 32'd0);
    expect_v("restart_clear_er", 32'd0);
    cyc();
    btn_start = 1'b0;
    check(32'(state)); check(32'(engine_reset));
    expect_v("restart_p0_er", 32'd1);
    expect_v("restart_p0_level", 32'd0);
    expect_v("restart_p0_score", 32'd0);
    cyc();
    check(32'(engine_reset)); check(32'(level)); check(32'(score));
    expect_v("restart_p1_er", 32'd0);
    cyc();
    check(32'(engine_reset));
    wait_tick("restart_tick", 9);
    expect_v("restart_queue_flushed", 32'd0);
    check(32'(direction));

    // 6. same-cycle up+left with direction right, then reset mid-PLAY
    btn_right = 1'b1; cyc(); btn_right = 1'b0;
    wait_tick("right_tick", 9);
    expect_v("dir_right", 32'd1);
    check(32'(direction));
    btn_up = 1'b1; btn_left = 1'b1; cyc(); btn_up = 1'b0; btn_left = 1'b0;
    wait_tick("up_tick", 9);
    expect_v("dir_up_priority", 32'd0);
    check(32'(direction));
    repeat (9) cyc();
    reset = 1'b1;
    expect_v("midreset_move_tick", 32'd0);
    expect_v("midreset_state", 32'd0);
    expect_v("midreset_engine_reset", 32'd1);
    cyc();
    reset = 1'b0;
    check(32'(move_tick)); check(32'(state)); check(32'(engine_reset));
    expect_v("idle_no_ticks", 32'd0);
    count_ticks(20, n);
    check(32'(n));
    expect_v("idle_state_kept", 32'd0);
    check(32'(state));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
